dcache_wb: RTL and testbench
============================

# dcache_wb

Direct-mapped, write-back, write-allocate data cache that acts as the responder on the core's D-cache port (ren/wen/addr/wdata → stall/rdata). It sits between the pipeline's MEM stage and a slow block-wide memory. It serves hits in zero cycles and holds the core stalled through write-back and refill on a miss. The same block, tied to wen=0, serves as the instruction cache.

## Interface
- NUM_BLOCKS, 8: cache lines; power of two. INDEX_W = log2(NUM_BLOCKS).
- WORDS_PER_BLOCK, 4: fixed; one line = 128 bits = one memory beat.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset; asynchronous and active-high.
- proc_ren  in  1  core read request.
- proc_wen  in  1  core write request; has priority if both requests are high.
- proc_addr  in  30  word address: [1:0] word-in-line, [INDEX_W+1:2] index, upper bits tag (25 bits at default).
- proc_wdata  in  32  write data; stored byte-order-agnostic.
- proc_stall  out  1  high while the request is not yet satisfied.
- proc_rdata  out  32  read data; valid when proc_ren=1 and proc_stall=0.
- mem_read  out  1  line refill request.
- mem_write  out  1  line write-back request.
- mem_addr  out  28  line address {tag,index}.
- mem_wdata  out  128  write-back line; word 0 in [31:0].
- mem_rdata  in  128  refill line; word 0 in [31:0].
- mem_ready  in  1  one-cycle acknowledge; completes the current mem_read or mem_write.

## Operation
- Per line state: valid, dirty, tag, 4×32 data. Reset clears every valid and dirty bit. Data and tag contents are don't-care after reset.
- hit = valid[idx] && tag[idx]==proc_addr tag. A request exists when proc_ren or proc_wen is high.
- FSM states: IDLE, WRITEBACK, ALLOCATE.
- IDLE, no request: proc_stall=0, no state change.
- IDLE, read hit: proc_stall=0, proc_rdata=data[idx][word], combinational.
- IDLE, write hit: proc_stall=0. At the edge: data[idx][word]←proc_wdata, dirty[idx]←1.
- IDLE, miss with clean or invalid line: proc_stall=1, go to ALLOCATE.
- IDLE, miss with dirty valid line: proc_stall=1, go to WRITEBACK.
- WRITEBACK:
  - Outputs: mem_write=1, mem_addr={tag[idx],idx}, mem_wdata=data[idx], proc_stall=1.
  - On mem_ready: go to ALLOCATE.
- ALLOCATE:
  - Outputs: mem_read=1, mem_addr={proc tag,idx}, proc_stall=1.
  - On mem_ready: data[idx]←mem_rdata, tag←proc tag, valid←1, dirty←0, go to IDLE.
- Back in IDLE the request hits and is served normally. A pending write is merged then, and the line becomes dirty.
- The core holds proc_ren, proc_wen, proc_addr and proc_wdata stable while proc_stall=1. The cache does not register them.
- mem_read and mem_write are never high together.
- Outside WRITEBACK: mem_write=0 and mem_wdata=0. Outside WRITEBACK/ALLOCATE: mem_read=0 and mem_addr=0.
- proc_rdata=0 whenever no read hit is being served in IDLE.

## Timing
- Reset values of all outputs: proc_stall=0, proc_rdata=0, mem_read=0, mem_write=0, mem_addr=0, mem_wdata=0. FSM=IDLE.
- Reset asserted mid-WRITEBACK or mid-ALLOCATE: immediate return to IDLE, mem requests drop asynchronously, all lines invalid. No partial line update.
- Hit latency: 0 cycles (stall never asserted).
- Clean miss: stall for 1 + Lr cycles, where Lr is the cycles of mem_read until mem_ready, then 1 IDLE cycle to serve.
- Dirty miss: adds Lw cycles of mem_write until mem_ready.
- Total stall cycles = Lw + Lr + 1 at minimum. With Lw=Lr=1: stall is high for the cycles WB, AL, IDLE-serve-edge, i.e. the core sees stall=0 in the 3rd cycle after the miss is first presented.
- mem_ready is sampled only in WRITEBACK/ALLOCATE and ignored in IDLE.
- mem_ready in the first cycle of a state is legal: 1-cycle transaction.
- Request changes the cycle after stall falls: a new lookup, no bubble.
- Index aliasing: a miss whose victim line holds the same index with a different tag always evicts. Associativity is not supported.

## Test plan
- Reset then read addr 0x0000_0010: stall=1, mem_read=1 with mem_addr=0x000_0004. Memory returns 128'h…_DDDD_CCCC_BBBB_AAAA after 3 cycles. Then stall=0, rdata=0x AAAA word; a read of 0x11 then hits with 0 stall and rdata = word 1.
- Write 0x1234_5678 to a resident line: no stall, no mem traffic; a following read returns 0x1234_5678.
- Dirty eviction: write to addr 0x00, then read addr 0x20, which has the same index (0) and a different tag. mem_write=1 at mem_addr=0x000_0000 carrying 0x1234_5678 in word 0. Then mem_read at mem_addr=0x000_0008. Never both high at once.
- Write miss on clean index 5: refill only, no mem_write. After refill the written word is merged and the line is dirty. A later conflicting miss writes it back.
- Assert rst during ALLOCATE with mem_ready low: mem_read drops the same cycle, stall=0. A re-read of the same address misses again.
- No request, with mem_ready pulsed spuriously in IDLE: no state change, all mem outputs 0.

Source files
------------

// File: rtl/dcache_wb.sv
// Direct-mapped write-back, write-allocate data cache between the core MEM stage and block-wide memory.
// Hits are served combinationally; a miss stalls the core through optional write-back, then refill.
module dcache_wb #(
    parameter int NUM_BLOCKS      = 8,
    parameter int WORDS_PER_BLOCK = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         proc_ren,
    input  logic         proc_wen,
    input  logic [29:0]  proc_addr,
    input  logic [31:0]  proc_wdata,
    output logic         proc_stall,
    output logic [31:0]  proc_rdata,
    output logic         mem_read,
    output logic         mem_write,
    output logic [27:0]  mem_addr,
    output logic [127:0] mem_wdata,
    input  logic [127:0] mem_rdata,
    input  logic         mem_ready
);
    localparam int INDEX_W = $clog2(NUM_BLOCKS);
    localparam int TAG_W   = 28 - INDEX_W;
    localparam int LINE_W  = WORDS_PER_BLOCK * 32;

    typedef enum logic [1:0] {IDLE, WRITEBACK, ALLOCATE} state_t;

    state_t                  state_q;
    logic [NUM_BLOCKS-1:0]   valid_q;
    logic [NUM_BLOCKS-1:0]   dirty_q;
    logic [TAG_W-1:0]        tag_q  [NUM_BLOCKS];
    logic [LINE_W-1:0]       data_q [NUM_BLOCKS];

    logic [INDEX_W-1:0] idx;
    logic [1:0]         word;
    logic [TAG_W-1:0]   ptag;
    logic               req;
    logic               hit;

    assign word = proc_addr[1:0];
    assign idx  = proc_addr[INDEX_W+1:2];
    assign ptag = proc_addr[29:INDEX_W+2];
    assign req  = proc_ren | proc_wen;
    assign hit  = valid_q[idx] && (tag_q[idx] == ptag);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            valid_q <= '0;
            dirty_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (proc_wen && hit) begin
                        dirty_q[idx] <= 1'b1;
                    end else if (req && !hit) begin
                        state_q <= (valid_q[idx] && dirty_q[idx]) ? WRITEBACK : ALLOCATE;
                    end
                end
                WRITEBACK: begin
                    if (mem_ready) state_q <= ALLOCATE;
                end
                ALLOCATE: begin
                    if (mem_ready) begin
                        valid_q[idx] <= 1'b1;
                        dirty_q[idx] <= 1'b0;
                        state_q      <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Line storage carries no reset: contents are meaningless until valid is set.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state_q == IDLE && proc_wen && hit) begin
                data_q[idx][32*word +: 32] <= proc_wdata;
            end else if (state_q == ALLOCATE && mem_ready) begin
                data_q[idx] <= mem_rdata;
                tag_q[idx]  <= ptag;
            end
        end
    end

    always_comb begin
        proc_stall = (state_q != IDLE) || (req && !hit);
        proc_rdata = '0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        case (state_q)
            IDLE: begin
                if (proc_ren && !proc_wen && hit) proc_rdata = data_q[idx][32*word +: 32];
            end
            WRITEBACK: begin
                mem_write = 1'b1;
                mem_addr  = {tag_q[idx], idx};
                mem_wdata = data_q[idx];
            end
            ALLOCATE: begin
                mem_read = 1'b1;
                mem_addr = {ptag, idx};
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_dcache_wb.sv
// Directed bench for dcache_wb: refill, hits, write merge, dirty eviction, reset abort, idle mem_ready.
module tb_dcache_wb;
    logic         clk = 1'b0;
    logic         rst;
    logic         proc_ren, proc_wen;
    logic [29:0]  proc_addr;
    logic [31:0]  proc_wdata;
    logic         proc_stall;
    logic [31:0]  proc_rdata;
    logic         mem_read, mem_write;
    logic [27:0]  mem_addr;
    logic [127:0] mem_wdata, mem_rdata;
    logic         mem_ready;

    int checks = 0;
    int errors = 0;

    dcache_wb dut (
        .clk(clk), .rst(rst),
        .proc_ren(proc_ren), .proc_wen(proc_wen), .proc_addr(proc_addr),
        .proc_wdata(proc_wdata), .proc_stall(proc_stall), .proc_rdata(proc_rdata),
        .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic mem_idle_chk(input string tag);
        chk({tag, "_mrd"},   128'(mem_read),  128'd0);
        chk({tag, "_mwr"},   128'(mem_write), 128'd0);
        chk({tag, "_maddr"}, 128'(mem_addr),  128'd0);
        chk({tag, "_mwd"},   mem_wdata,       128'd0);
    endtask

    initial begin
        rst = 1'b1; proc_ren = 0; proc_wen = 0; proc_addr = '0; proc_wdata = '0;
        mem_rdata = '0; mem_ready = 0;
        step();
        chk("rst_stall", 128'(proc_stall), 128'd0);
        chk("rst_rdata", 128'(proc_rdata), 128'd0);
        mem_idle_chk("rst");
        rst = 1'b0;

        // Clean read miss with 3-cycle memory latency
        step();
        proc_ren = 1; proc_addr = 30'h10; #1;
        chk("m1_stall_idle", 128'(proc_stall), 128'd1);
        chk("m1_mrd_idle", 128'(mem_read), 128'd0);
        step();
        chk("m1_mrd", 128'(mem_read), 128'd1);
        chk("m1_maddr", 128'(mem_addr), 128'h4);
        chk("m1_mwr", 128'(mem_write), 128'd0);
        chk("m1_stall_al", 128'(proc_stall), 128'd1);
        step();
        step();
        chk("m1_mrd_wait", 128'(mem_read), 128'd1);
        mem_ready = 1; mem_rdata = 128'hDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA;
        step();
        mem_ready = 0; #1;
        chk("m1_stall_done", 128'(proc_stall), 128'd0);
        chk("m1_rdata_w0", 128'(proc_rdata), 128'hAAAAAAAA);
        chk("m1_mrd_done", 128'(mem_read), 128'd0);
        step();
        proc_addr = 30'h11; #1;
        chk("h1_stall", 128'(proc_stall), 128'd0);
        chk("h1_rdata", 128'(proc_rdata), 128'hBBBBBBBB);
        proc_addr = 30'h13; #1;
        chk("h3_rdata", 128'(proc_rdata), 128'hDDDDDDDD);

        // Write hit then read back
        step();
        proc_ren = 0; proc_wen = 1; proc_addr = 30'h12; proc_wdata = 32'h12345678; #1;
        chk("wh_stall", 128'(proc_stall), 128'd0);
        chk("wh_rdata", 128'(proc_rdata), 128'd0);
        mem_idle_chk("wh");
        step();
        proc_wen = 0; proc_ren = 1; #1;
        chk("wh_readback", 128'(proc_rdata), 128'h12345678);

        // Write miss on index 0, then conflicting read evicts the dirty line
        step();
        proc_ren = 0; proc_wen = 1; proc_addr = 30'h00; proc_wdata = 32'h12345678; #1;
        chk("ev_wmiss_stall", 128'(proc_stall), 128'd1);
        step();
        chk("ev_al_mrd", 128'(mem_read), 128'd1);
        chk("ev_al_mwr", 128'(mem_write), 128'd0);
        chk("ev_al_maddr", 128'(mem_addr), 128'h0);
        mem_ready = 1; mem_rdata = 128'h33333333_22222222_11111111_00000000;
        step();
        mem_ready = 0; #1;
        chk("ev_merge_stall", 128'(proc_stall), 128'd0);
        step();
        proc_wen = 0; proc_ren = 1; proc_addr = 30'h20; #1;
        chk("ev_miss_stall", 128'(proc_stall), 128'd1);
        step();
        chk("ev_wb_mwr", 128'(mem_write), 128'd1);
        chk("ev_wb_mrd", 128'(mem_read), 128'd0);
        chk("ev_wb_maddr", 128'(mem_addr), 128'h0);
        chk("ev_wb_mwd", mem_wdata, 128'h33333333_22222222_11111111_12345678);
        step();
        chk("ev_wb_hold", 128'(mem_write), 128'd1);
        mem_ready = 1;
        step();
        mem_rdata = 128'h88888888_77777777_66666666_55555555; #1;
        chk("ev_al_mrd2", 128'(mem_read), 128'd1);
        chk("ev_al_mwr2", 128'(mem_write), 128'd0);
        chk("ev_al_maddr2", 128'(mem_addr), 128'h8);
        chk("ev_al_stall", 128'(proc_stall), 128'd1);
        step();
        mem_ready = 0; #1;
        chk("ev_done_stall", 128'(proc_stall), 128'd0);
        chk("ev_done_rdata", 128'(proc_rdata), 128'h55555555);

        // Write miss on clean index 5: refill only, merge, later written back
        step();
        proc_ren = 0; proc_wen = 1; proc_addr = 30'h15; proc_wdata = 32'hCAFEF00D;
        step();
        chk("wm_al_mwr", 128'(mem_write), 128'd0);
        chk("wm_al_mrd", 128'(mem_read), 128'd1);
        chk("wm_al_maddr", 128'(mem_addr), 128'h5);
        mem_ready = 1; mem_rdata = 128'hA3A3A3A3_A2A2A2A2_A1A1A1A1_A0A0A0A0;
        step();
        mem_ready = 0; #1;
        chk("wm_merge_stall", 128'(proc_stall), 128'd0);
        step();
        proc_wen = 0; proc_ren = 1; proc_addr = 30'h34;
        step();
        chk("wm_wb_mwr", 128'(mem_write), 128'd1);
        chk("wm_wb_maddr", 128'(mem_addr), 128'h5);
        chk("wm_wb_mwd", mem_wdata, 128'hA3A3A3A3_A2A2A2A2_CAFEF00D_A0A0A0A0);
        mem_ready = 1;
        step();
        mem_rdata = 128'h0; #1;
        chk("wm_al_maddr2", 128'(mem_addr), 128'hD);
        step();
        mem_ready = 0; #1;
        chk("wm_done_stall", 128'(proc_stall), 128'd0);

        // Reset during ALLOCATE aborts the refill
        step();
        proc_addr = 30'h44;
        step();
        chk("ra_al_mrd", 128'(mem_read), 128'd1);
        rst = 1; proc_ren = 0; #1;
        chk("ra_rst_mrd", 128'(mem_read), 128'd0);
        chk("ra_rst_stall", 128'(proc_stall), 128'd0);
        step();
        rst = 0; proc_ren = 1; proc_addr = 30'h10; #1;
        chk("ra_old_line_invalid", 128'(proc_stall), 128'd1);
        proc_addr = 30'h44; #1;
        chk("ra_rereadmiss", 128'(proc_stall), 128'd1);
        step();
        mem_ready = 1; mem_rdata = 128'h0D0D0D0D_0C0C0C0C_0B0B0B0B_0A0A0A0A; #1;
        chk("ra_al_maddr", 128'(mem_addr), 128'h11);
        step();
        mem_ready = 0; #1;
        chk("ra_done_rdata", 128'(proc_rdata), 128'h0A0A0A0A);

        // Spurious mem_ready in IDLE with no request
        step();
        proc_ren = 0; mem_ready = 1;
        step();
        mem_ready = 0; #1;
        chk("sp_stall", 128'(proc_stall), 128'd0);
        chk("sp_rdata", 128'(proc_rdata), 128'd0);
        mem_idle_chk("sp");
        proc_ren = 1; proc_addr = 30'h45; #1;
        chk("sp_hit_stall", 128'(proc_stall), 128'd0);
        chk("sp_hit_rdata", 128'(proc_rdata), 128'h0B0B0B0B);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    always @(negedge clk) begin
        if (!rst && mem_read && mem_write) begin
            checks++;
            errors++;
            $error("FAIL mem_rd_wr_overlap observed=11 expected=not both");
        end
    end
endmodule
